// File: rtl/cache_fill_multi.sv
// cache_fill_multi
// Direct-mapped cache data store with per-line valid bits and a line-fill
// sequencer. Tags and hit/miss decisions on tags live outside; this block
// only knows which lines hold complete, trustworthy data.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   rd_req/line/offset    byte read request (result one cycle later)
//   rd_valid/hit/data     registered read result; data is zero on a miss
//   wr_en/line/offset/data CPU byte write (does not touch valid bits)
//   inv_en/inv_line       clear one line's valid bit
//   fill_start/fill_line  begin refilling a whole line from memory
//   fill_busy/fill_done   sequencer active / one-cycle completion pulse
//   mem_req/line/offset   beat request to memory, held until mem_valid
//   mem_valid/mem_data    beat returned by memory
//   line_valid            per-line valid bits
//
// Memory handshake: mem_req stays high with mem_line/mem_offset stable until
// a cycle with mem_valid=1; that cycle transfers exactly one byte. mem_valid
// is ignored whenever the sequencer is not requesting.
module cache_fill_multi #(
  parameter int LINES      = 4,
  parameter int LINE_BYTES = 8,
  parameter int DATA_W     = 8,
  parameter int LW         = $clog2(LINES),
  parameter int OW         = $clog2(LINE_BYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [LW-1:0]     rd_line,
  input  logic [OW-1:0]     rd_offset,
  output logic              rd_valid,
  output logic              rd_hit,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [LW-1:0]     wr_line,
  input  logic [OW-1:0]     wr_offset,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              inv_en,
  input  logic [LW-1:0]     inv_line,
  input  logic              fill_start,
  input  logic [LW-1:0]     fill_line,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              mem_req,
  output logic [LW-1:0]     mem_line,
  output logic [OW-1:0]     mem_offset,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_data,
  output logic [LINES-1:0]  line_valid
);

  localparam int AW = LW + OW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  // Sequencer state; visible hierarchically as fill_state for checkers.
  fill_state_t fill_state;

  logic [DATA_W-1:0] data_q [LINES*LINE_BYTES];

  logic [AW-1:0]     rd_addr;
  logic [AW-1:0]     wr_addr;
  logic [AW-1:0]     fill_addr;
  logic              fill_we;
  logic              cpu_we;
  logic [DATA_W-1:0] rd_byte;

  assign rd_addr   = {rd_line, rd_offset};
  assign wr_addr   = {wr_line, wr_offset};
  assign fill_addr = {mem_line, mem_offset};
  assign fill_we   = (fill_state == REQ) && mem_valid;
  // A fill beat to the same byte overrides the CPU write.
  assign cpu_we    = wr_en && !(fill_we && (fill_addr == wr_addr));

  // Write-first read: return the byte as it will be after this edge.
  always_comb begin
    rd_byte = data_q[rd_addr];
    if (cpu_we && (wr_addr == rd_addr)) rd_byte = wr_data;
    if (fill_we && (fill_addr == rd_addr)) rd_byte = mem_data;
  end

  // Data array: not reset, partial fill data survives a reset.
  always_ff @(posedge clk) begin
    if (cpu_we)  data_q[wr_addr]   <= wr_data;
    if (fill_we) data_q[fill_addr] <= mem_data;
  end

  // Read port: hit reflects valid bits as they stood before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_hit   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      rd_hit   <= rd_req && line_valid[rd_line];
      rd_data  <= (rd_req && line_valid[rd_line]) ? rd_byte : '0;
    end
  end

  // Fill sequencer and valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_state <= IDLE;
      fill_busy  <= 1'b0;
      fill_done  <= 1'b0;
      mem_req    <= 1'b0;
      mem_line   <= '0;
      mem_offset <= '0;
      line_valid <= '0;
    end else begin
      fill_done <= 1'b0;
      case (fill_state)
        IDLE: begin
          if (fill_start) begin
            mem_line              <= fill_line;
            mem_offset            <= '0;
            mem_req               <= 1'b1;
            fill_busy             <= 1'b1;
            line_valid[fill_line] <= 1'b0;
            fill_state            <= REQ;
          end
        end
        REQ: begin
          if (mem_valid) begin
            if (mem_offset == OW'(LINE_BYTES - 1)) begin
              mem_req    <= 1'b0;
              fill_done  <= 1'b1;
              fill_state <= DONE;
            end else begin
              mem_offset <= mem_offset + 1'b1;
            end
          end
        end
        DONE: begin
          line_valid[mem_line] <= 1'b1;
          fill_busy            <= 1'b0;
          fill_state           <= IDLE;
        end
        default: fill_state <= IDLE;
      endcase
      // Last assignment wins: invalidate beats a same-edge fill completion.
      if (inv_en) line_valid[inv_line] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_fill_multi.sv
// Testbench for cache_fill_multi: directed sequences, a table of read/write
// vectors with constant expectations, and a randomized phase. Every cycle is
// also checked against a behavioural model of the cache contents and the
// fill progress (a beat counter per fill).
module tb_cache_fill_multi;

  localparam int LINES      = 4;
  localparam int LINE_BYTES = 8;
  localparam int DATA_W     = 8;
  localparam int LW         = 2;
  localparam int OW         = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              rd_req;
  logic [LW-1:0]     rd_line;
  logic [OW-1:0]     rd_offset;
  logic              rd_valid;
  logic              rd_hit;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [LW-1:0]     wr_line;
  logic [OW-1:0]     wr_offset;
  logic [DATA_W-1:0] wr_data;
  logic              inv_en;
  logic [LW-1:0]     inv_line;
  logic              fill_start;
  logic [LW-1:0]     fill_line;
  logic              fill_busy;
  logic              fill_done;
  logic              mem_req;
  logic [LW-1:0]     mem_line;
  logic [OW-1:0]     mem_offset;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_data;
  logic [LINES-1:0]  line_valid;

  cache_fill_multi #(.LINES(LINES), .LINE_BYTES(LINE_BYTES), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_line(rd_line), .rd_offset(rd_offset),
    .rd_valid(rd_valid), .rd_hit(rd_hit), .rd_data(rd_data),
    .wr_en(wr_en), .wr_line(wr_line), .wr_offset(wr_offset), .wr_data(wr_data),
    .inv_en(inv_en), .inv_line(inv_line),
    .fill_start(fill_start), .fill_line(fill_line),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .mem_req(mem_req), .mem_line(mem_line), .mem_offset(mem_offset),
    .mem_valid(mem_valid), .mem_data(mem_data),
    .line_valid(line_valid)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] m_data [LINES][LINE_BYTES];
  logic [LINES-1:0]  m_valid;
  bit                m_active;  // waiting for beats
  bit                m_done;    // completion cycle
  int                m_cnt;     // beats received so far
  int                m_line;

  task automatic model_reset();
    m_valid  = '0;
    m_active = 0;
    m_done   = 0;
    m_cnt    = 0;
    m_line   = 0;
  endtask

  // ---------------- driver ----------------
  task automatic idle_inputs();
    rd_req = 0; rd_line = '0; rd_offset = '0;
    wr_en = 0; wr_line = '0; wr_offset = '0; wr_data = '0;
    inv_en = 0; inv_line = '0;
    fill_start = 0; fill_line = '0;
    mem_valid = 0; mem_data = '0;
  endtask

  // One clock: predict from current inputs, advance, compare.
  task automatic step();
    logic              e_rv;
    logic              e_hit;
    logic [DATA_W-1:0] e_data;
    e_rv  = rd_req;
    e_hit = rd_req && m_valid[rd_line];
    if (wr_en) m_data[wr_line][wr_offset] = wr_data;
    if (m_active && mem_valid) m_data[m_line][m_cnt] = mem_data;
    e_data = e_hit ? m_data[rd_line][rd_offset] : '0;
    if (m_done) begin
      m_valid[m_line] = 1'b1;
      m_done = 0;
    end else if (m_active) begin
      if (mem_valid) begin
        m_cnt++;
        if (m_cnt == LINE_BYTES) begin
          m_active = 0;
          m_done   = 1;
        end
      end
    end else if (fill_start) begin
      m_line = int'(fill_line);
      m_valid[m_line] = 1'b0;
      m_cnt = 0;
      m_active = 1;
    end
    if (inv_en) m_valid[inv_line] = 1'b0;
    @(posedge clk);
    #1;
    chk("rd_valid", rd_valid, e_rv);
    if (e_rv) begin
      chk("rd_hit", rd_hit, e_hit);
      chk("rd_data", rd_data, e_data);
    end
    chk("line_valid", line_valid, m_valid);
    chk("mem_req", mem_req, m_active);
    if (m_active) begin
      chk("mem_line", mem_line, m_line);
      chk("mem_offset", mem_offset, m_cnt);
    end
    chk("fill_busy", fill_busy, m_active || m_done);
    chk("fill_done", fill_done, m_done);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [LW-1:0]     rl;
    logic [OW-1:0]     ro;
    logic              we;
    logic [LW-1:0]     wl;
    logic [OW-1:0]     wo;
    logic [DATA_W-1:0] wd;
    logic              ie;
    logic [LW-1:0]     il;
    logic              eh;
    logic [DATA_W-1:0] ed;
  } vec_t;

  vec_t tbl [10];

  // ---------------- test ----------------
  initial begin
    for (int l = 0; l < LINES; l++)
      for (int o = 0; o < LINE_BYTES; o++) m_data[l][o] = '0;
    model_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mem_req", mem_req, 0);
    chk("reset_fill_busy", fill_busy, 0);
    chk("reset_rd_valid", rd_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_line_valid", line_valid, 4'b0000);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_mem_offset", mem_offset, 0);
    chk("reset_fill_done", fill_done, 0);

    // Read miss after reset.
    rd_req = 1; rd_line = 2; rd_offset = 5;
    step();
    chk("miss_rd_valid", rd_valid, 1);
    chk("miss_rd_hit", rd_hit, 0);
    chk("miss_rd_data", rd_data, 0);
    idle_inputs();

    // Back-to-back fill of line 1 with 8'h10..8'h17.
    fill_start = 1; fill_line = 1;
    step();
    fill_start = 0;
    for (int b = 0; b < LINE_BYTES; b++) begin
      chk("fill1_offset", mem_offset, b);
      mem_valid = 1; mem_data = 8'h10 + 8'(b);
      step();
    end
    chk("fill1_done_cycle9", fill_done, 1);
    idle_inputs();
    step();
    chk("fill1_line_valid", line_valid, 4'b0010);
    rd_req = 1; rd_line = 1; rd_offset = 3;
    step();
    chk("fill1_hit", rd_hit, 1);
    chk("fill1_data", rd_data, 8'h13);
    idle_inputs();

    // Fill line 0 with three stall cycles before every beat.
    fill_start = 1; fill_line = 0;
    step();
    fill_start = 0;
    for (int b = 0; b < LINE_BYTES; b++) begin
      mem_valid = 0;
      for (int s = 0; s < 3; s++) begin
        step();
        chk("stall_mem_req", mem_req, 1);
        chk("stall_offset", mem_offset, b);
      end
      mem_valid = 1; mem_data = 8'hA0 + 8'(b);
      step();
    end
    // Read of the line during its completion cycle still misses.
    idle_inputs();
    rd_req = 1; rd_line = 0; rd_offset = 0;
    step();
    chk("done_cycle_read_miss", rd_hit, 0);
    idle_inputs();

    // Table: reads with write-first, invalidate, and miss cases.
    tbl[0] = '{2'd0, 3'd0, 1'b0, 2'd0, 3'd0, 8'h00, 1'b0, 2'd0, 1'b1, 8'hA0};
    tbl[1] = '{2'd0, 3'd7, 1'b0, 2'd0, 3'd0, 8'h00, 1'b0, 2'd0, 1'b1, 8'hA7};
    tbl[2] = '{2'd1, 3'd3, 1'b1, 2'd1, 3'd3, 8'hAA, 1'b0, 2'd0, 1'b1, 8'hAA};
    tbl[3] = '{2'd1, 3'd3, 1'b0, 2'd0, 3'd0, 8'h00, 1'b1, 2'd1, 1'b1, 8'hAA};
    tbl[4] = '{2'd1, 3'd3, 1'b0, 2'd0, 3'd0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00};
    tbl[5] = '{2'd2, 3'd5, 1'b0, 2'd0, 3'd0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00};
    tbl[6] = '{2'd0, 3'd4, 1'b1, 2'd0, 3'd5, 8'h55, 1'b0, 2'd0, 1'b1, 8'hA4};
    tbl[7] = '{2'd0, 3'd5, 1'b0, 2'd0, 3'd0, 8'h00, 1'b0, 2'd0, 1'b1, 8'h55};
    tbl[8] = '{2'd3, 3'd0, 1'b0, 2'd0, 3'd0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00};
    tbl[9] = '{2'd0, 3'd2, 1'b1, 2'd1, 3'd2, 8'h77, 1'b0, 2'd0, 1'b1, 8'hA2};
    for (int i = 0; i < 10; i++) begin
      rd_req = 1; rd_line = tbl[i].rl; rd_offset = tbl[i].ro;
      wr_en = tbl[i].we; wr_line = tbl[i].wl; wr_offset = tbl[i].wo; wr_data = tbl[i].wd;
      inv_en = tbl[i].ie; inv_line = tbl[i].il;
      step();
      chk($sformatf("tbl%0d_hit", i), rd_hit, tbl[i].eh);
      chk($sformatf("tbl%0d_data", i), rd_data, tbl[i].ed);
    end
    idle_inputs();

    // Fill line 2; CPU write collides with the fill beat at offset 4;
    // fill_start while busy and during completion is ignored.
    fill_start = 1; fill_line = 2;
    step();
    for (int b = 0; b < LINE_BYTES; b++) begin
      fill_start = (b == 2); fill_line = 3;
      wr_en = (b == 4); wr_line = 2; wr_offset = 4; wr_data = 8'h55;
      mem_valid = 1; mem_data = 8'h20 + 8'(b);
      step();
    end
    idle_inputs();
    fill_start = 1; fill_line = 3;
    step();
    chk("start_in_done_ignored", fill_busy, 0);
    idle_inputs();
    rd_req = 1; rd_line = 2; rd_offset = 4;
    step();
    chk("collide_hit", rd_hit, 1);
    chk("collide_fill_wins", rd_data, 8'h24);
    chk("collide_line_valid", line_valid, 4'b0101);
    idle_inputs();

    // Reset in the middle of a fill after three beats.
    fill_start = 1; fill_line = 3;
    step();
    fill_start = 0;
    for (int b = 0; b < 3; b++) begin
      mem_valid = 1; mem_data = 8'h30 + 8'(b);
      step();
    end
    mem_valid = 0;
    #2;
    rst = 1'b1;
    #1;
    chk("midreset_mem_req", mem_req, 0);
    chk("midreset_fill_busy", fill_busy, 0);
    chk("midreset_line_valid", line_valid, 4'b0000);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    fill_start = 1; fill_line = 3;
    step();
    fill_start = 0;
    for (int b = 0; b < LINE_BYTES; b++) begin
      mem_valid = 1; mem_data = 8'h40 + 8'(b);
      step();
    end
    idle_inputs();
    step();
    chk("refill_line_valid", line_valid, 4'b1000);
    rd_req = 1; rd_line = 3; rd_offset = 6;
    step();
    chk("refill_data", rd_data, 8'h46);
    idle_inputs();

    // Randomized traffic checked against the model.
    for (int c = 0; c < 2000; c++) begin
      rd_req     = 1'($urandom_range(0, 1));
      rd_line    = LW'($urandom_range(0, LINES - 1));
      rd_offset  = OW'($urandom_range(0, LINE_BYTES - 1));
      wr_en      = ($urandom_range(0, 9) < 3);
      wr_line    = LW'($urandom_range(0, LINES - 1));
      wr_offset  = OW'($urandom_range(0, LINE_BYTES - 1));
      wr_data    = DATA_W'($urandom);
      inv_en     = ($urandom_range(0, 19) == 0);
      inv_line   = LW'($urandom_range(0, LINES - 1));
      fill_start = ($urandom_range(0, 4) == 0);
      fill_line  = LW'($urandom_range(0, LINES - 1));
      mem_valid  = ($urandom_range(0, 9) < 6);
      mem_data   = DATA_W'($urandom);
      step();
    end
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cache_fill_multi.md
Name: cache_fill_multi

Overview:
Parametrised successor to the fixed 4-line x 8-byte cache data array. It is a direct-mapped cache data store with per-line valid bits, a registered byte read port with hit/miss status, and a CPU byte-write port. A line-fill sequencer refills one whole line from the memory side, one byte per beat, over a req/valid handshake. It sits between the CPU-side cache controller (tags and hit logic are external) and the memory interface.

Parameters:
LINES, 4, number of cache lines (power of 2, >=2)
LINE_BYTES, 8, bytes per line (power of 2, >=2)
DATA_W, 8, byte width in bits
LW, $clog2(LINES), line index width (derived)
OW, $clog2(LINE_BYTES), offset width (derived)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
rd_req  in  1  read request
rd_line  in  LW  read line index
rd_offset  in  OW  read byte offset
rd_valid  out  1  one-cycle pulse, read result valid
rd_hit  out  1  qualified by rd_valid; 1 = line valid at sample time
rd_data  out  DATA_W  read byte; qualified by rd_valid && rd_hit
wr_en  in  1  CPU byte write
wr_line  in  LW  write line index
wr_offset  in  OW  write byte offset
wr_data  in  DATA_W  write byte
inv_en  in  1  invalidate line inv_line
inv_line  in  LW  line to invalidate
fill_start  in  1  start refill of fill_line
fill_line  in  LW  line to refill
fill_busy  out  1  sequencer not IDLE
fill_done  out  1  one-cycle pulse, fill complete
mem_req  out  1  memory beat request
mem_line  out  LW  line being fetched
mem_offset  out  OW  byte offset being fetched
mem_valid  in  1  memory beat data valid
mem_data  in  DATA_W  memory beat data
line_valid  out  LINES  per-line valid bits

Behaviour:
- Reset (async, rst=1): line_valid=0, rd_valid=0, rd_hit=0, rd_data=0, fill_busy=0, fill_done=0, mem_req=0, mem_line=0, mem_offset=0, FSM=IDLE. Data array contents are not reset.
- Read: rd_req sampled at edge N; rd_valid=1 after edge N (latency 1).
  - rd_hit = line_valid[rd_line] as it stood before edge N.
  - rd_data = array byte. Write-first: a same-cycle write (CPU or fill) to the same line/offset is returned.
  - When rd_hit=0, rd_data=0.
- CPU write: wr_en writes one byte at the edge and does not change line_valid.
  - If a fill beat writes the same line/offset in the same cycle, the fill byte wins.
  - CPU writes to the line under fill are otherwise accepted.
- Invalidate: inv_en clears line_valid[inv_line] at the edge. If it coincides with fill completion on the same line, invalidate wins (line ends invalid).
- Fill FSM states: IDLE, REQ, DONE.
  - IDLE: fill_start -> latch fill_line, clear line_valid[fill_line], mem_offset=0, mem_req=1, go to REQ. fill_start is ignored when not IDLE.
  - REQ: mem_req held at 1 with stable mem_line/mem_offset until mem_valid=1.
    - On mem_valid, write mem_data to array[mem_line][mem_offset].
    - If mem_offset == LINE_BYTES-1: mem_req=0, go to DONE. Otherwise mem_offset+1, stay in REQ.
    - Back-to-back beats (mem_valid every cycle) give LINE_BYTES cycles per fill.
  - DONE: one cycle. fill_done=1, set line_valid[mem_line], go to IDLE. fill_start is ignored while in DONE.
  - mem_valid outside REQ is ignored.
- A read of the line under fill returns rd_hit=0 until the cycle after DONE. Valid is visible to a read sampled in the cycle after fill_done.
- Reset mid-fill: FSM returns to IDLE, mem_req drops immediately, line stays invalid, and partial data remains in the array.
- Offsets wrap only through the terminal check; there is no modulo access beyond LINE_BYTES-1.

Test Plan:
- Reset, then rd_req line 2 offset 5 -> next cycle rd_valid=1, rd_hit=0, rd_data=0; line_valid=4'b0000.
- fill_start line 1, mem_valid every cycle with data 8'h10..8'h17 -> mem_offset steps 0..7, fill_done pulses 9 cycles after start, line_valid=4'b0010; read line 1 offset 3 -> rd_hit=1, rd_data=8'h13.
- Fill line 0 with mem_valid stalled 3 cycles between beats -> mem_req and mem_offset are held during each stall, and all 8 bytes are written correctly.
- CPU write line 1 offset 3 8'hAA in the same cycle as a read of line 1 offset 3 -> rd_data=8'hAA; then inv_en line 1 -> the next read has rd_hit=0.
- During fill of line 2, issue a CPU write to line 2 offset 4 in the cycle the fill beat for offset 4 arrives (8'h55 vs fill 8'h24) -> array holds 8'h24; a second fill_start while busy is ignored.
- Assert rst in the middle of a fill (after 3 beats) -> mem_req=0 and fill_busy=0 asynchronously, line_valid stays 0; a new fill after reset completes normally.
